// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encoding and
// default parameter values.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_PC_STEP  = 1;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Power-of-two circular buffer holding fetched {pc, instr} entries.
// Clear has priority over push/pop; head_data reads as zero when empty.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; it is only observable through
  // head_data, which is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: issues reads to a 1-cycle synchronous ROM while buffer
// credit remains, queues returned words, and flushes on redirect using an epoch bit.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_addr,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [INSTR_W-1:0]     rom_q,
  output logic                   out_valid,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              epoch_q, epoch_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_epoch_q, inflight_epoch_d;

  logic               issue;
  logic               credit;
  logic [CNT_W:0]     committed;
  logic               push, pop;
  logic [ENTRY_W-1:0] head_data;

  // Occupied entries plus the read whose data lands this cycle bound new issues.
  assign committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit    = committed < (CNT_W + 1)'(DEPTH);

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q;
    issue            = 1'b0;
    if (redirect_valid) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_addr;
      epoch_d    = ~epoch_q;
    end else begin
      case (state_q)
        FETCH: begin
          if (credit) begin
            issue      = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          end else begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (credit) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
    inflight_d       = issue;
    inflight_pc_d    = issue ? fetch_pc_q : inflight_pc_q;
    inflight_epoch_d = issue ? epoch_q : inflight_epoch_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FETCH;
      fetch_pc_q       <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  // Returning data from an older epoch belongs to a squashed path.
  assign push     = inflight_q && (inflight_epoch_q == epoch_q);
  assign pop      = out_valid && out_ready;
  assign rom_addr = reset ? RESET_PC : fetch_pc_q;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({inflight_pc_q, rom_q}),
    .pop       (pop),
    .clear     (redirect_valid),
    .head_data (head_data),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_pc    = head_data[ENTRY_W-1:INSTR_W];
  assign out_instr = head_data[INSTR_W-1:0];

endmodule
